ysyx_24120009_exu_ctrl: RTL and testbench
=========================================

YSYX_24120009_EXU_CTRL -- requirements
Module: ysyx_24120009_EXU_CTRL

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `ysyx_24120009_DATA_WIDTH (32), datapath width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max MEM_WAIT cycles before error.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports listed below, clock and reset first.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  decoded/executed op offered
- in_ready  out  1  op accepted when in_valid & in_ready
- in_result  in  DATA_WIDTH  ALU result (memory address for loads/stores)
- in_wdata  in  DATA_WIDTH  store data
- in_wmask  in  4  store byte mask
- in_mem_ren  in  1  load
- in_mem_wen  in  1  store
- in_wb_sel  in  2  00 none, 01 pc_plus4, 10 result, 11 load data
- in_pc_plus4  in  DATA_WIDTH  link value
- in_rd  in  5  destination register
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  request is store
- mem_req_addr  out  DATA_WIDTH  request address
- mem_req_wdata  out  DATA_WIDTH  store data
- mem_req_wmask  out  4  store mask
- mem_rsp_valid  in  1  response strobe, one cycle
- mem_rsp_rdata  in  DATA_WIDTH  load data
- mem_rsp_err  in  1  access fault
- wb_valid  out  1  write-back offered
- wb_ready  in  1  write-back consumed
- wb_en  out  1  register write enable (wb_sel != 00 and no error)
- wb_rd  out  5  destination register
- wb_data  out  DATA_WIDTH  write-back value
- wb_err  out  1  access fault or timeout on this op
- busy  out  1  state != IDLE

Function
REQ-004 SHALL implement FSM IDLE, MEM_REQ, MEM_WAIT, WB; in_ready = (state==IDLE).
REQ-005 SHALL on IDLE handshake latch all in_* fields; if in_mem_ren|in_mem_wen go MEM_REQ, else go WB with wb_data selected by in_wb_sel (00 -> 0).
REQ-006 SHALL assert mem_req_valid only in MEM_REQ with latched addr/wdata/wmask/wen stable until mem_req_ready; on handshake go MEM_WAIT.
REQ-007 SHALL in MEM_WAIT, on mem_rsp_valid, capture mem_rsp_rdata (loads) and mem_rsp_err, then go WB; wb_data for wb_sel=11 is captured rdata.
REQ-008 SHALL count MEM_WAIT cycles (8-bit min., saturating); at count==TIMEOUT with no response go WB with wb_err=1, wb_en=0, wb_data=0.
REQ-009 SHALL treat response arriving same cycle as timeout as valid (response wins, no error).
REQ-010 SHALL ignore mem_rsp_valid outside MEM_WAIT.
REQ-011 SHALL hold wb_valid in WB with stable outputs until wb_ready; on handshake return IDLE; no new op accepted same cycle (min. 2 cycles per ALU op, 4 per memory op with zero-wait memory).
REQ-012 SHALL force wb_en=0 whenever wb_err=1; stores with wb_sel=00 give wb_en=0.
REQ-013 SHALL treat in_mem_ren & in_mem_wen both set as store.

Reset
REQ-014 SHALL on rst low, immediately and regardless of clk: state IDLE, in_ready=1, mem_req_valid=0, wb_valid=0, wb_en=0, wb_err=0, busy=0, latched data/counter 0.
REQ-015 SHALL abandon any in-flight request on reset; a later stray mem_rsp_valid is ignored per REQ-010.

Structure
REQ-016 SHALL take DATA_WIDTH and wb_sel encodings (WB_NONE/PC4/ALU/MEM) from the shared defs header; FSM state encodings local.
REQ-017 SHALL reuse ysyx_24120009_MuxKeyWithDefault for wb_data select; no other sub-module.

Verification
REQ-018 ALU op result=0x10, wb_sel=10, rd=5, wb_ready=1 -> wb_valid 1 cycle after accept, wb_data=0x10, wb_en=1, wb_rd=5.
REQ-019 Load addr=0x80000004, mem_req_ready held low 3 cycles, rsp rdata=0xDEADBEEF after 2 cycles -> req fields stable while waiting, wb_data=0xDEADBEEF, wb_en=1.
REQ-020 Store wdata=0x12345678 wmask=0xF wb_sel=00 -> mem_req_wen=1, wb_valid with wb_en=0, wb_err=0.
REQ-021 Load, no response, TIMEOUT=4 -> WB after 4 MEM_WAIT cycles, wb_err=1, wb_en=0, wb_data=0; response on 4th cycle -> no error.
REQ-022 wb_ready low 5 cycles then high -> wb outputs stable, in_ready=0 until handshake.
REQ-023 rst low during MEM_WAIT, later mem_rsp_valid -> outputs at reset values immediately, stray response ignored, next op completes normally.

Source files
------------

// File: rtl/ysyx_24120009_exu_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: datapath width and
// write-back source encodings.
package ysyx_24120009_exu_ctrl_pkg;

  localparam int ysyx_24120009_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_PC4  = 2'b01,
    WB_ALU  = 2'b10,
    WB_MEM  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/ysyx_24120009_exu_ctrl_muxkey.sv
// Key-indexed selector with a fallback value; each lut entry is {key, data},
// entry 0 in the least significant bits.
module ysyx_24120009_MuxKeyWithDefault #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                  key,
  input  logic [DATA_LEN-1:0]                 default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                 out
);

  localparam int ENTRY_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out = default_out;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*ENTRY_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*ENTRY_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_24120009_exu_ctrl.sv
// Execute-stage controller: accepts one op, optionally performs a memory
// access with timeout, then offers the write-back until it is consumed.
module ysyx_24120009_exu_ctrl
  import ysyx_24120009_exu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ysyx_24120009_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [3:0]            in_wmask,
  input  logic                  in_mem_ren,
  input  logic                  in_mem_wen,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [4:0]            in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_en,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_WAIT = 2'b10,
    WB       = 2'b11
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [3:0]            wmask;
    logic                  ren;
    logic                  wen;
    logic [1:0]            wb_sel;
    logic [4:0]            rd;
  } op_t;

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  state_e                state_q, state_d;
  op_t                   op_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  timed_out;

  assign accept    = in_valid && in_ready;
  // A response in the final wait cycle takes priority over the timeout.
  assign timed_out = (state_q == MEM_WAIT) && !mem_rsp_valid
                     && (int'(cnt_q) + 1 >= TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: default assignment first keeps this block from inferring a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_valid) state_d = (in_mem_ren || in_mem_wen) ? MEM_REQ : WB;
      MEM_REQ:  if (mem_req_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_rsp_valid || timed_out) state_d = WB;
      WB:       if (wb_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      MEM_REQ: mem_req_valid = 1'b1;
      WB:      wb_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        op_q.result   <= in_result;
        op_q.wdata    <= in_wdata;
        op_q.pc_plus4 <= in_pc_plus4;
        op_q.wmask    <= in_wmask;
        op_q.ren      <= in_mem_ren;
        op_q.wen      <= in_mem_wen;
        op_q.wb_sel   <= in_wb_sel;
        op_q.rd       <= in_rd;
        rdata_q       <= '0;
        err_q         <= 1'b0;
        cnt_q         <= '0;
      end
      if (state_q == MEM_WAIT) begin
        if (mem_rsp_valid) begin
          // A set write enable makes the op a store, so only pure loads take data.
          if (op_q.ren && !op_q.wen) rdata_q <= mem_rsp_rdata;
          err_q <= mem_rsp_err;
        end
        if (timed_out) err_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  ysyx_24120009_MuxKeyWithDefault #(
    .NR_KEY  (4),
    .KEY_LEN (2),
    .DATA_LEN(DATA_WIDTH)
  ) u_wb_mux (
    .key        (op_q.wb_sel),
    .default_out({DATA_WIDTH{1'b0}}),
    .lut        ({WB_MEM,  rdata_q,
                  WB_ALU,  op_q.result,
                  WB_PC4,  op_q.pc_plus4,
                  WB_NONE, {DATA_WIDTH{1'b0}}}),
    .out        (sel_data)
  );

  assign mem_req_wen   = op_q.wen;
  assign mem_req_addr  = op_q.result;
  assign mem_req_wdata = op_q.wdata;
  assign mem_req_wmask = op_q.wmask;

  // Any fault (access error or timeout) zeroes the write-back value.
  assign wb_data = err_q ? '0 : sel_data;
  assign wb_rd   = op_q.rd;
  assign wb_err  = wb_valid && err_q;
  assign wb_en   = wb_valid && (op_q.wb_sel != WB_NONE) && !err_q;

endmodule

// File: tb/tb_ysyx_24120009_exu_ctrl.sv
// Self-checking bench: per-cycle comparison of the controller against a
// transaction-level model, with directed and randomized ops.
module tb_ysyx_24120009_exu_ctrl;
  import ysyx_24120009_exu_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_result = '0, in_wdata = '0, in_pc_plus4 = '0;
  logic [3:0]    in_wmask = '0;
  logic          in_mem_ren = 1'b0, in_mem_wen = 1'b0;
  logic [1:0]    in_wb_sel = '0;
  logic [4:0]    in_rd = '0;
  logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [DW-1:0] mem_req_addr, mem_req_wdata;
  logic [3:0]    mem_req_wmask;
  logic          mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
  logic [DW-1:0] mem_rsp_rdata = '0;
  logic          wb_valid, wb_ready = 1'b0, wb_en, wb_err, busy;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;

  always #5 clk = ~clk;

  ysyx_24120009_exu_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_wdata(in_wdata), .in_wmask(in_wmask), .in_mem_ren(in_mem_ren),
    .in_mem_wen(in_mem_wen), .in_wb_sel(in_wb_sel), .in_pc_plus4(in_pc_plus4),
    .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] result, wdata, pc4;
    logic [3:0]    wmask;
    logic          ren, wen;
    logic [1:0]    sel;
    logic [4:0]    rd;
  } op_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model view of the op in flight and what the outputs must show.
  op_t           cur;
  logic          exp_busy = 1'b0, exp_req = 1'b0, exp_wb = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_en = 1'b0, exp_err = 1'b0;

  // Snapshot of the write-back seen for the latest op, for literal checks.
  logic [DW-1:0] lw_data;
  logic          lw_en, lw_err, lw_req_wen;
  logic [4:0]    lw_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-back outcome from the op's rules: faults zero everything, stores never return load data.
  function automatic void predict(input op_t op, input bit timeout, input bit err,
                                  input logic [DW-1:0] rdata, output logic [DW-1:0] data,
                                  output logic en, output logic fault);
    bit is_mem = op.ren || op.wen;
    fault = is_mem && (timeout || err);
    case (op.sel)
      2'b00:   data = '0;
      2'b01:   data = op.pc4;
      2'b10:   data = op.result;
      default: data = (op.ren && !op.wen) ? rdata : '0;
    endcase
    if (fault) data = '0;
    en = (op.sel != 2'b00) && !fault;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    int kind = $urandom_range(0, 3);
    op.result = $urandom;
    op.wdata  = $urandom;
    op.pc4    = $urandom;
    op.wmask  = 4'($urandom);
    op.rd     = 5'($urandom);
    op.ren    = (kind == 1) || (kind == 3);
    op.wen    = (kind == 2) || (kind == 3);
    op.sel    = (kind == 1) ? 2'($urandom) : 2'($urandom_range(0, 2));
    return op;
  endfunction

  task automatic drive_in(input op_t op);
    in_result   = op.result;
    in_wdata    = op.wdata;
    in_pc_plus4 = op.pc4;
    in_wmask    = op.wmask;
    in_mem_ren  = op.ren;
    in_mem_wen  = op.wen;
    in_wb_sel   = op.sel;
    in_rd       = op.rd;
  endtask

  task automatic scramble_in();
    op_t junk = rand_op();
    drive_in(junk);
  endtask

  always @(negedge clk) begin
    check("in_ready", in_ready, !exp_busy);
    check("busy", busy, exp_busy);
    check("mem_req_valid", mem_req_valid, exp_req);
    check("wb_valid", wb_valid, exp_wb);
    if (exp_req) begin
      check("mem_req_addr", mem_req_addr, cur.result);
      check("mem_req_wdata", mem_req_wdata, cur.wdata);
      check("mem_req_wmask", mem_req_wmask, cur.wmask);
      check("mem_req_wen", mem_req_wen, cur.wen);
    end
    if (exp_wb) begin
      check("wb_rd", wb_rd, cur.rd);
      check("wb_data", wb_data, exp_data);
      check("wb_en", wb_en, exp_en);
      check("wb_err", wb_err, exp_err);
    end
  end

  // rsp_at: MEM_WAIT cycle (1-based) carrying the response, 0 = never respond.
  task automatic run_op(input op_t op, input int req_wait, input int rsp_at, input int wb_wait,
                        input logic rsp_err, input logic [DW-1:0] rdata, input bit strays);
    bit is_mem  = op.ren || op.wen;
    bit timeout = is_mem && (rsp_at == 0);
    int n_wait;
    drive_in(op);
    in_valid = 1'b1;
    cur = op;
    predict(op, timeout, rsp_err, rdata, exp_data, exp_en, exp_err);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_in();
    exp_busy = 1'b1;
    if (is_mem) begin
      exp_req = 1'b1;
      lw_req_wen = mem_req_wen;
      for (int i = 0; i < req_wait; i++) begin
        if (strays) begin
          mem_rsp_valid = 1'($urandom_range(0, 1));
          mem_rsp_err   = 1'b1;
          mem_rsp_rdata = $urandom;
          in_valid      = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      in_valid      = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      exp_req = 1'b0;
      n_wait = timeout ? TO : rsp_at;
      for (int k = 1; k <= n_wait; k++) begin
        if (k == rsp_at) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rdata;
          mem_rsp_err   = rsp_err;
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
    exp_wb  = 1'b1;
    lw_data = wb_data;
    lw_en   = wb_en;
    lw_err  = wb_err;
    lw_rd   = wb_rd;
    for (int i = 0; i < wb_wait; i++) begin
      if (strays) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_err   = 1'b1;
        in_valid      = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    wb_ready = 1'b1;
    in_valid = strays ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    in_valid = 1'b0;
    exp_wb   = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin
    op_t op;
    #2 rst = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset mem_req_valid", mem_req_valid, 1'b0);
    check("reset wb_valid", wb_valid, 1'b0);
    check("reset wb_en", wb_en, 1'b0);
    check("reset wb_data", wb_data, 32'h0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    // ALU op: write-back one cycle after accept.
    op = '{result: 32'h10, wdata: 32'h0, pc4: 32'h4, wmask: 4'h0, ren: 1'b0, wen: 1'b0, sel: 2'b10, rd: 5'd5};
    run_op(op, 0, 0, 0, 1'b0, 32'h0, 1'b0);
    check("alu wb_data", lw_data, 32'h10);
    check("alu wb_en", lw_en, 1'b1);
    check("alu wb_rd", lw_rd, 5'd5);

    // Load with a stalled request and a response on the second wait cycle.
    op = '{result: 32'h80000004, wdata: 32'h0, pc4: 32'h0, wmask: 4'h0, ren: 1'b1, wen: 1'b0, sel: 2'b11, rd: 5'd9};
    run_op(op, 3, 2, 0, 1'b0, 32'hDEADBEEF, 1'b1);
    check("load wb_data", lw_data, 32'hDEADBEEF);
    check("load wb_en", lw_en, 1'b1);

    // Store without write-back.
    op = '{result: 32'h100, wdata: 32'h12345678, pc4: 32'h0, wmask: 4'hF, ren: 1'b0, wen: 1'b1, sel: 2'b00, rd: 5'd0};
    run_op(op, 0, 1, 0, 1'b0, 32'h0, 1'b0);
    check("store req_wen", lw_req_wen, 1'b1);
    check("store wb_en", lw_en, 1'b0);
    check("store wb_err", lw_err, 1'b0);

    // Timeout, then a response landing on the last allowed cycle.
    op = '{result: 32'h200, wdata: 32'h0, pc4: 32'h0, wmask: 4'h0, ren: 1'b1, wen: 1'b0, sel: 2'b11, rd: 5'd3};
    run_op(op, 0, 0, 0, 1'b0, 32'h0, 1'b0);
    check("timeout wb_err", lw_err, 1'b1);
    check("timeout wb_en", lw_en, 1'b0);
    check("timeout wb_data", lw_data, 32'h0);
    run_op(op, 0, TO, 0, 1'b0, 32'hCAFEF00D, 1'b0);
    check("late rsp wb_err", lw_err, 1'b0);
    check("late rsp wb_data", lw_data, 32'hCAFEF00D);

    // Access fault on a load.
    run_op(op, 1, 1, 0, 1'b1, 32'h55AA55AA, 1'b0);
    check("fault wb_err", lw_err, 1'b1);
    check("fault wb_data", lw_data, 32'h0);

    // Write-back held off for five cycles.
    op = '{result: 32'h0, wdata: 32'h0, pc4: 32'h1004, wmask: 4'h0, ren: 1'b0, wen: 1'b0, sel: 2'b01, rd: 5'd1};
    run_op(op, 0, 0, 5, 1'b0, 32'h0, 1'b1);
    check("link wb_data", lw_data, 32'h1004);

    for (int n = 0; n < 80; n++) begin
      int rsp_at = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
      run_op(rand_op(), $urandom_range(0, 3), rsp_at, $urandom_range(0, 3),
             1'($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on memory, then a stray response.
    op = '{result: 32'h300, wdata: 32'h0, pc4: 32'h0, wmask: 4'h0, ren: 1'b1, wen: 1'b0, sel: 2'b11, rd: 5'd7};
    drive_in(op);
    cur = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_busy = 1'b1;
    exp_req  = 1'b1;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    exp_req = 1'b0;
    @(posedge clk); #2;
    exp_busy = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 1'b1);
    check("midreset busy", busy, 1'b0);
    check("midreset wb_valid", wb_valid, 1'b0);
    check("midreset wb_err", wb_err, 1'b0);
    check("midreset wb_rd", wb_rd, 5'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_err   = 1'b1;
    mem_rsp_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check("stray busy", busy, 1'b0);
    check("stray wb_valid", wb_valid, 1'b0);
    run_op(op, 1, 1, 1, 1'b0, 32'h0BADF00D, 1'b0);
    check("post reset wb_data", lw_data, 32'h0BADF00D);
    check("post reset wb_en", lw_en, 1'b1);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
